alu_controller: RTL and testbench
=================================

# alu_controller

Multi-cycle control FSM that drives the ALU datapath. It latches a 16-bit instruction and decodes it into register-file, operand-register and ALU controls, then steps the datapath through read-A, read-B, compute and write-back. It also supplies the sign-extended immediate and shift code. It sits between the instruction source and the datapath, and is the only block that generates `ALUop`.

## Interface
- No parameters; widths are fixed at 16-bit data, 3-bit register numbers and 2-bit ALU op.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; `reset`=0 at a rising edge forces reset state.
- `in` input 16: instruction word.
- `load` input 1: capture `in` into the instruction register (IR).
- `s` input 1: start executing the IR.
- `w` output 1: 1 when idle (WAIT state).
- `illegal` output 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `readnum` output 3: register-file read address.
- `writenum` output 3: register-file write address.
- `write` output 1: register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` output 1 each: enables for operand registers A and B, result register C, and the status register.
- `asel` output 1: 1 forces ALU A input to 0.
- `bsel` output 1: 1 selects the immediate on the B input.
- `vsel` output 1: 0 = write back C, 1 = write back `sximm8`.
- `ALUop` output 2: 00 add, 01 subtract, 10 and, 11 not-B.
- `shift` output 2: shifter code for the B path.
- `sximm8` output 16: IR[7:0] sign-extended.

## Operation
- IR fields:
  - opcode = IR[15:13], op = IR[12:11].
  - Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0].
  - sh = IR[4:3], imm8 = IR[7:0].
- `load` is honoured only when `w`=1; it is ignored while busy.
- `s` is honoured only in WAIT.
- States: WAIT, DECODE, GET_A, GET_B, CALC, WR_REG, WR_IMM.
- WAIT → DECODE when `s`=1; otherwise stay in WAIT.
- From DECODE:
  - opcode 110, op 10 (MOV Rn,#imm8) → WR_IMM → WAIT.
  - opcode 110, op 00 (MOV Rd,Rm,sh) → GET_B → CALC (asel=1, ALUop=00) → WR_REG → WAIT.
  - opcode 101, op 00 / 01 / 10 (ADD, CMP, AND) → GET_A → GET_B → CALC.
  - opcode 101, op 11 (MVN Rd,Rm) → GET_B → CALC (ALUop=11) → WR_REG.
  - Any other code → WAIT, with `illegal`=1 in DECODE.
- From CALC:
  - CMP (op 01) → WAIT. CALC asserts `loads`=1 and `loadc`=0.
  - All other instructions → WR_REG. CALC asserts `loadc`=1 and `loads`=0.
- CALC drives ALUop = op for opcode 101, and 00 for MOV.
- State outputs:
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - WR_REG: writenum=Rd, vsel=0, write=1.
  - WR_IMM: writenum=Rn, vsel=1, write=1.
- All control outputs are Moore, decoded from the state and IR. Unlisted enables are 0.
- `bsel`=0 in every current state; the port is reserved for immediate ALU ops.
- `shift`=sh in GET_B and CALC, and 00 otherwise.
- `sximm8` is continuous: {{8{IR[7]}}, IR[7:0]}.

## Timing
- Reset values:
  - state = WAIT, IR = 0.
  - w=1, all enables 0, illegal=0.
  - readnum=writenum=0, ALUop=00, shift=00, sximm8=0.
- Reset wins over `s` and `load` in the same cycle. Reset mid-instruction aborts it, and no write occurs in the following cycle.
- `load`=1 and `s`=1 in the same WAIT cycle: IR captures `in`, and DECODE (next cycle) decodes the new IR.
- `w` falls in the cycle after `s` is sampled. It rises when the FSM re-enters WAIT.
- Latency from `s` edge to return to WAIT, in cycles:
  - ADD/AND: 5.
  - CMP: 4.
  - MVN/MOV Rd: 4.
  - MOV imm: 2.
  - Illegal: 1.
- `s` held high continuously restarts on the same IR immediately after each WAIT cycle.

## Configuration
- `ALU_CTRL_SHIFT_EN` defined: `shift` follows IR[4:3] as above.
- `ALU_CTRL_SHIFT_EN` undefined: `shift` is constant 00, and the sh field is ignored (no shifter in the datapath).

## Test plan
- Reset with `reset`=0, `s`=1, `load`=1 → after the edge, w=1, all enables 0, state WAIT, IR=0.
- `in`=16'hD1F6 (MOV R1,#-10), load, s → sximm8=16'hFFF6; next cycle WR_IMM with writenum=1, vsel=1, write=1; w=1 two cycles after s.
- `in`=16'hA0A2 (ADD R5,R0,R2) → sequence: loada with readnum=0; loadb with readnum=2; loadc with ALUop=00; write with writenum=5; w=1 after 5 cycles.
- `in`=16'hA901 (CMP R1,R1) → CALC asserts loads=1, loadc=0, ALUop=01; no write pulse; w=1 after 4 cycles.
- `in`=16'hC0B8 (MOV R5,R0,sh=11) → asel=1 in CALC; shift=11 with the macro defined and 00 without it.
- `in`=16'hE000 (illegal) → illegal=1 for exactly one cycle, no enables asserted, w=1 after 1 cycle. A `load` with a new `in` during ADD execution leaves the IR unchanged.

Source files
------------

// File: rtl/alu_controller.sv
// Multi-cycle control FSM for the ALU datapath: latches an instruction, decodes it and sequences
// read-A / read-B / compute / write-back. Optional macro ALU_CTRL_SHIFT_EN routes IR[4:3] to shift.
module alu_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic        illegal,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic        vsel,
   output logic [1:0]  ALUop,
   output logic [1:0]  shift,
   output logic [15:0] sximm8
);

   typedef enum logic [2:0] {
      WAIT   = 3'd0,
      DECODE = 3'd1,
      GET_A  = 3'd2,
      GET_B  = 3'd3,
      CALC   = 3'd4,
      WR_REG = 3'd5,
      WR_IMM = 3'd6
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] ir, ir_nxt;

   logic        w_d, illegal_d, write_d, vsel_d, asel_d;
   logic        loada_d, loadb_d, loadc_d, loads_d;
   logic [2:0]  readnum_d, writenum_d;
   logic [1:0]  aluop_d, shift_d, sh_n;

   function automatic logic is_mov_imm(input logic [15:0] i);
      return (i[15:13] == 3'b110) && (i[12:11] == 2'b10);
   endfunction

   function automatic logic is_mov_reg(input logic [15:0] i);
      return (i[15:13] == 3'b110) && (i[12:11] == 2'b00);
   endfunction

   function automatic logic is_alu(input logic [15:0] i);
      return i[15:13] == 3'b101;
   endfunction

   function automatic logic is_legal(input logic [15:0] i);
      return is_mov_imm(i) || is_mov_reg(i) || is_alu(i);
   endfunction

   assign sximm8 = {{8{ir[7]}}, ir[7:0]};
   assign bsel   = 1'b0;

`ifdef ALU_CTRL_SHIFT_EN
   assign sh_n = ir_nxt[4:3];
`else
   assign sh_n = 2'b00;
`endif

   // Next state and next IR; the IR only accepts new words while idle
   always_comb begin
      ir_nxt = ir;
      if (state == WAIT && load)
         ir_nxt = in;
      state_nxt = state;
      case (state)
         WAIT:    if (s) state_nxt = DECODE;
         DECODE: begin
            if (is_mov_imm(ir))
               state_nxt = WR_IMM;
            else if (is_mov_reg(ir) || (is_alu(ir) && ir[12:11] == 2'b11))
               state_nxt = GET_B;
            else if (is_alu(ir))
               state_nxt = GET_A;
            else
               state_nxt = WAIT;
         end
         GET_A:   state_nxt = GET_B;
         GET_B:   state_nxt = CALC;
         CALC:    state_nxt = (is_alu(ir) && ir[12:11] == 2'b01) ? WAIT : WR_REG;
         WR_REG:  state_nxt = WAIT;
         WR_IMM:  state_nxt = WAIT;
         default: state_nxt = WAIT;
      endcase
   end

   // Moore outputs of the state being entered, so the registered copies line up with it
   always_comb begin
      w_d        = (state_nxt == WAIT);
      illegal_d  = (state_nxt == DECODE) && !is_legal(ir_nxt);
      readnum_d  = '0;
      writenum_d = '0;
      write_d    = 1'b0;
      loada_d    = 1'b0;
      loadb_d    = 1'b0;
      loadc_d    = 1'b0;
      loads_d    = 1'b0;
      asel_d     = 1'b0;
      vsel_d     = 1'b0;
      aluop_d    = 2'b00;
      shift_d    = 2'b00;
      case (state_nxt)
         GET_A: begin
            readnum_d = ir_nxt[10:8];
            loada_d   = 1'b1;
         end
         GET_B: begin
            readnum_d = ir_nxt[2:0];
            loadb_d   = 1'b1;
            shift_d   = sh_n;
         end
         CALC: begin
            shift_d = sh_n;
            asel_d  = is_mov_reg(ir_nxt);
            aluop_d = is_alu(ir_nxt) ? ir_nxt[12:11] : 2'b00;
            if (is_alu(ir_nxt) && ir_nxt[12:11] == 2'b01)
               loads_d = 1'b1;
            else
               loadc_d = 1'b1;
         end
         WR_REG: begin
            writenum_d = ir_nxt[7:5];
            write_d    = 1'b1;
         end
         WR_IMM: begin
            writenum_d = ir_nxt[10:8];
            write_d    = 1'b1;
            vsel_d     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= WAIT;
         ir       <= '0;
         w        <= 1'b1;
         illegal  <= 1'b0;
         readnum  <= '0;
         writenum <= '0;
         write    <= 1'b0;
         loada    <= 1'b0;
         loadb    <= 1'b0;
         loadc    <= 1'b0;
         loads    <= 1'b0;
         asel     <= 1'b0;
         vsel     <= 1'b0;
         ALUop    <= 2'b00;
         shift    <= 2'b00;
      end else begin
         state    <= state_nxt;
         ir       <= ir_nxt;
         w        <= w_d;
         illegal  <= illegal_d;
         readnum  <= readnum_d;
         writenum <= writenum_d;
         write    <= write_d;
         loada    <= loada_d;
         loadb    <= loadb_d;
         loadc    <= loadc_d;
         loads    <= loads_d;
         asel     <= asel_d;
         vsel     <= vsel_d;
         ALUop    <= aluop_d;
         shift    <= shift_d;
      end
   end

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller: a per-instruction step-list model checked every cycle,
// plus directed instructions with hand-computed latency, pulse and field expectations.
module tb_alu_controller;

   logic        clk, reset, load, s;
   logic [15:0] in;
   logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel, vsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  ALUop, shift;
   logic [15:0] sximm8;

   alu_controller dut (
      .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
      .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift), .sximm8(sximm8)
   );

   typedef struct packed {
      logic       w;
      logic       illegal;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       vsel;
      logic [1:0] aluop;
      logic [1:0] shift;
   } outs_t;

`ifdef ALU_CTRL_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   int    n_chk = 0;
   int    n_pass = 0;
   bit    chk_en = 0;
   outs_t q[$];
   logic [15:0] m_ir = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
   endtask

   // Expected output sequence of one instruction, from the DECODE cycle onwards
   task automatic build_plan(input logic [15:0] i);
      outs_t o;
      logic [2:0] opc, rn, rd, rm;
      logic [1:0] op, sh;
      bit mov_imm, mov_reg, alu;
      opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; rm = i[2:0];
      sh = SHIFT_EN ? i[4:3] : 2'b00;
      mov_imm = (opc == 3'b110) && (op == 2'b10);
      mov_reg = (opc == 3'b110) && (op == 2'b00);
      alu     = (opc == 3'b101);
      o = '0; o.illegal = !(mov_imm || mov_reg || alu); q.push_back(o);
      if (mov_imm) begin
         o = '0; o.writenum = rn; o.write = 1; o.vsel = 1; q.push_back(o);
      end else if (alu || mov_reg) begin
         if (alu && op != 2'b11) begin
            o = '0; o.readnum = rn; o.loada = 1; q.push_back(o);
         end
         o = '0; o.readnum = rm; o.loadb = 1; o.shift = sh; q.push_back(o);
         o = '0; o.shift = sh; o.asel = mov_reg; o.aluop = alu ? op : 2'b00;
         if (alu && op == 2'b01) o.loads = 1; else o.loadc = 1;
         q.push_back(o);
         if (!(alu && op == 2'b01)) begin
            o = '0; o.writenum = rd; o.write = 1; q.push_back(o);
         end
      end
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
         m_ir = '0;
      end else if (q.size() != 0) begin
         q.delete(0);
      end else begin
         if (load) m_ir = in;
         if (s) build_plan(m_ir);
      end
   end

   always @(negedge clk) begin
      outs_t act, req;
      if (chk_en) begin
         act = {w, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, ALUop, shift};
         req = '0;
         req.w = 1'b1;
         if (q.size() != 0) req = q[0];
         check("outputs", {12'd0, act}, {12'd0, req});
         check("sximm8", {16'd0, sximm8}, {16'd0, {{8{m_ir[7]}}, m_ir[7:0]}});
      end
   end

   task automatic run_instr(input string nm, input logic [15:0] instr, input int exp_lat,
                            input int exp_wr, input int exp_ill, input logic [2:0] exp_wn,
                            input logic [1:0] exp_sh, input logic [15:0] exp_sx, input bit poke);
      int lat, wr, il;
      logic [2:0] wn;
      logic [1:0] shv;
      @(negedge clk); in = instr; load = 1; s = 1;
      @(negedge clk); load = 0; s = 0; in = 16'h0000;
      lat = 0; wr = 0; il = 0; wn = 0; shv = 0;
      while (w !== 1'b1 && lat < 20) begin
         if (write) begin wr++; wn = writenum; end
         if (illegal) il++;
         if (asel) shv = shift;
         if (poke && lat == 1) begin load = 1; in = 16'hC1E5; end
         else load = 0;
         @(negedge clk); lat++;
      end
      load = 0;
      check({nm, "_latency"}, lat, exp_lat);
      check({nm, "_writes"}, wr, exp_wr);
      check({nm, "_illegal"}, il, exp_ill);
      check({nm, "_writenum"}, {29'd0, wn}, {29'd0, exp_wn});
      check({nm, "_calc_shift"}, {30'd0, shv}, {30'd0, exp_sh});
      check({nm, "_sximm8"}, {16'd0, sximm8}, {16'd0, exp_sx});
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 4))
         0: r[15:11] = 5'b11010;
         1: r[15:11] = 5'b11000;
         2, 3: r[15:13] = 3'b101;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      reset = 0; s = 1; load = 1; in = 16'hD1F6;
      @(negedge clk);
      chk_en = 1;
      check("reset_w", {31'd0, w}, 32'd1);
      check("reset_enables", {26'd0, write, loada, loadb, loadc, loads, illegal}, 32'd0);
      check("reset_sximm8", {16'd0, sximm8}, 32'd0);
      reset = 1; s = 0; load = 0;

      run_instr("mov_imm", 16'hD1F6, 2, 1, 0, 3'd1, 2'b00, 16'hFFF6, 0);
      run_instr("add",     16'hA0A2, 5, 1, 0, 3'd5, 2'b00, 16'hFFA2, 1);
      run_instr("cmp",     16'hA901, 4, 0, 0, 3'd0, 2'b00, 16'h0001, 0);
      run_instr("mov_reg", 16'hC0B8, 4, 1, 0, 3'd5, SHIFT_EN ? 2'b11 : 2'b00, 16'hFFB8, 0);
      run_instr("mvn",     16'hB8E3, 4, 1, 0, 3'd7, 2'b00, 16'hFFE3, 0);
      run_instr("illegal", 16'hE000, 1, 0, 1, 3'd0, 2'b00, 16'h0000, 0);
      run_instr("bad_mov", 16'hC800, 1, 0, 1, 3'd0, 2'b00, 16'h0000, 0);

      // Reset in the middle of an ADD
      @(negedge clk); in = 16'hA0A2; load = 1; s = 1;
      @(negedge clk); load = 0; s = 0;
      @(negedge clk); reset = 0;
      @(negedge clk); reset = 1;
      check("abort_w", {31'd0, w}, 32'd1);
      check("abort_write", {31'd0, write}, 32'd0);
      @(negedge clk);
      check("abort_write_next", {31'd0, write}, 32'd0);

      // s held high restarts back to back
      @(negedge clk); in = 16'hD3F0; load = 1; s = 1;
      @(negedge clk); load = 0;
      repeat (9) @(negedge clk);
      s = 0;
      for (int k = 0; k < 10 && w !== 1'b1; k++) @(negedge clk);

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 99) >= 3);
         load  = ($urandom_range(0, 99) < 30);
         s     = ($urandom_range(0, 99) < 40);
         in    = rand_instr();
      end
      @(negedge clk); reset = 1; load = 0; s = 0;
      repeat (8) @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
